rvga_fetch_queue: RTL

//  Instruction-fetch front end between the imem port (test_ddr or real memory) and rvga_top decode.

---
 rtl/rvga_fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rvga_fetch_queue.sv
// rvga_fetch_queue: instruction-fetch front end.
// Issues sequential imem reads with one request outstanding, buffers {pc, instr}
// pairs in a small FIFO for decode, and flushes on redirect. A response that
// belongs to a request issued before a redirect is dropped.
module rvga_fetch_queue #(
    parameter int          depth_p    = 4,
    parameter logic [31:0] reset_pc_p = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_r_v_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_resp_v_i,
    input  logic        redirect_v_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fe_v_o,
    input  logic        fe_ready_i,
    output logic [31:0] fe_instr_o,
    output logic [31:0] fe_pc_o
);

    localparam int aw_lp = $clog2(depth_p);
    localparam int cw_lp = aw_lp + 1;

    typedef logic [aw_lp-1:0] ptr_t;
    typedef logic [cw_lp-1:0] cnt_t;

    // FETCH: request outstanding at pc; STALL: FIFO full, no request;
    // DRAIN: waiting out a request that a redirect made stale.
    typedef enum logic [1:0] {
        st_fetch,
        st_stall,
        st_drain
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_addr, req_addr_next;
    ptr_t        rd_ptr, wr_ptr;
    cnt_t        count, count_next;
    logic [31:0] pc_mem    [depth_p];
    logic [31:0] instr_mem [depth_p];
    logic        push, pop, empty;
    logic [31:0] target;

    assign target      = redirect_pc_i & 32'hFFFF_FFFC;
    assign empty       = (count == '0);
    assign fe_v_o      = !empty && !redirect_v_i;
    assign pop         = fe_v_o && fe_ready_i;
    assign fe_pc_o     = pc_mem[rd_ptr];
    assign fe_instr_o  = instr_mem[rd_ptr];
    assign imem_r_v_o  = !rst_i && ((state == st_fetch) || (state == st_drain));
    assign imem_addr_o = (state == st_drain) ? req_addr : pc;

    // Only a live (non-stale) response arriving without a redirect is buffered.
    assign push = (state == st_fetch) && imem_resp_v_i && !redirect_v_i;

    // FIFO occupancy after this cycle's flush, push and pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        count_next = count;
        if (redirect_v_i) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + cnt_t'(1);
        end else if (!push && pop) begin
            count_next = count - cnt_t'(1);
        end
    end

    // Next-state, next-pc and stale-request address selection.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        case (state)
            st_fetch: begin
                if (redirect_v_i) begin
                    pc_next = target;
                    if (!imem_resp_v_i) begin
                        // The old request is still pending; keep presenting it.
                        req_addr_next = pc;
                        state_next    = st_drain;
                    end
                end else if (imem_resp_v_i) begin
                    pc_next = pc + 32'd4;
                    if (count_next == cnt_t'(depth_p)) begin
                        state_next = st_stall;
                    end
                end
            end
            st_stall: begin
                if (redirect_v_i) begin
                    pc_next    = target;
                    state_next = st_fetch;
                end else if (count_next < cnt_t'(depth_p)) begin
                    state_next = st_fetch;
                end
            end
            st_drain: begin
                if (redirect_v_i) begin
                    pc_next = target;
                end
                if (imem_resp_v_i) begin
                    state_next = st_fetch;
                end
            end
            default: state_next = st_fetch;
        endcase
    end

    // Control state, pc and FIFO pointers.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (rst_i) begin
            state    <= st_fetch;
            pc       <= reset_pc_p;
            req_addr <= reset_pc_p;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
            if (redirect_v_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ptr_t'(1);
                if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; count/pointers alone decide which entries are valid.
        if (push && !rst_i) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= imem_data_i;
        end
    end

endmodule
